// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT_W-bit digit per accepted
// cycle, LSD first, with word framing, stalls, mid-word restart and end-of-word flags.
module digit_serial_addsub #(
    parameter int DIGIT_W  = 1,
    parameter int WORD_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [DIGIT_W-1:0] s,
    output logic               out_valid,
    output logic               out_last,
    output logic               cout,
    output logic               ovf,
    output logic               aborted
);

    localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             carry, carry_nxt;
    logic             mode, mode_nxt;

    logic             start_p0, accept_p0, abort_p0, last_p0;
    logic             mode_p0, cin_p0;
    logic [DIGIT_W-1:0] eff_b_p0;
    logic [DIGIT_W:0]   sum_p0;
    logic [CNT_W-1:0]   idx_p0;

    // Signed overflow of the word: carry into the MSB differs from carry out of it.
    function automatic logic msb_overflow(input logic a_msb, input logic b_msb,
                                          input logic [DIGIT_W:0] sum);
        logic carry_into_msb;
        carry_into_msb = a_msb ^ b_msb ^ sum[DIGIT_W-1];
        return carry_into_msb ^ sum[DIGIT_W];
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        carry_nxt = carry;
        mode_nxt  = mode;

        start_p0  = in_valid & start;
        accept_p0 = in_valid & (start | (state == RUN));
        abort_p0  = start_p0 & (state == RUN);

        // A start digit takes its mode and the +1 for subtraction straight from sub.
        mode_p0  = start_p0 ? sub : mode;
        cin_p0   = start_p0 ? sub : carry;
        eff_b_p0 = y ^ {DIGIT_W{mode_p0}};
        sum_p0   = {1'b0, x} + {1'b0, eff_b_p0} + {{DIGIT_W{1'b0}}, cin_p0};

        idx_p0  = start_p0 ? '0 : cnt;
        last_p0 = (idx_p0 == LAST_IDX);

        if (accept_p0) begin
            carry_nxt = sum_p0[DIGIT_W];
            mode_nxt  = mode_p0;
            if (last_p0) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = idx_p0 + CNT_W'(1);
            end
        end
    end

    // Stage p0 -> p1: registered result digit and word flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            mode      <= 1'b0;
            s         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            carry     <= carry_nxt;
            mode      <= mode_nxt;
            out_valid <= accept_p0;
            out_last  <= accept_p0 & last_p0;
            cout      <= accept_p0 & last_p0 & sum_p0[DIGIT_W];
            ovf       <= accept_p0 & last_p0 &
                         msb_overflow(x[DIGIT_W-1], eff_b_p0[DIGIT_W-1], sum_p0);
            aborted   <= abort_p0;
            if (accept_p0) begin
                s <= sum_p0[DIGIT_W-1:0];
            end
        end
    end

endmodule
